// File: rtl/btn_pkg.sv
// Shared types, timing constants and helpers for the push-button conditioner.
package btn_pkg;

  // Per-channel debounce FSM states.
  typedef enum logic [1:0] {
    IDLE,          // stable released
    PRESS_WAIT,    // pressed seen, waiting for it to stay stable
    PRESSED,       // stable pressed
    RELEASE_WAIT   // released seen, waiting for it to stay stable
  } btn_state_e;

  // Board clock timing: about 10 ms debounce and 0.67 s long press.
  localparam int BOARD_DEBOUNCE_CYCLES   = 500000;
  localparam int BOARD_LONG_PRESS_CYCLES = 33333333;

  // Short values so simulations finish quickly.
  localparam int SIM_DEBOUNCE_CYCLES     = 8;
  localparam int SIM_LONG_PRESS_CYCLES   = 32;

  // Map a pad value to 1 = pressed, whatever the board wiring.
  function automatic logic normalise(input logic pad, input bit active_low);
    return active_low ? ~pad : pad;
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchroniser, debounce FSM with a stability
// counter, registered level and press/release strobes.
// Optional long-press strobe is compiled in with `define BTN_LONG_PRESS_EN.
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter bit ACTIVE_LOW        = 1'b1,
  parameter int DEBOUNCE_CYCLES   = BOARD_DEBOUNCE_CYCLES,
  parameter int LONG_PRESS_CYCLES = BOARD_LONG_PRESS_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_long
);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("btn_debounce_ch: DEBOUNCE_CYCLES must be >= 1");
  end
  if (LONG_PRESS_CYCLES < 1) begin : g_bad_long
    $error("btn_debounce_ch: LONG_PRESS_CYCLES must be >= 1");
  end

  localparam int   CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic PAD_IDLE = ACTIVE_LOW ? 1'b1 : 1'b0;

  logic [1:0]    sync_q;
  logic          pressed_s;
  btn_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;

  // Two-stage synchroniser for the asynchronous pad.
  // NOTE: the sync flops reset to the released pad value, not 0, so an
  // active-low button does not look pressed as soon as reset lets go.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= {2{PAD_IDLE}};
    else        sync_q <= {sync_q[0], btn_raw};
  end

  assign pressed_s = normalise(sync_q[1], ACTIVE_LOW);

  // Next-state logic: accept a new state only after DEBOUNCE_CYCLES stable samples.
  // NOTE: every signal gets a default first so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pressed_s) begin
          state_d = PRESS_WAIT;
          cnt_d   = CW'(1);
        end
      end
      PRESS_WAIT: begin
        if (!pressed_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CW'(DEBOUNCE_CYCLES)) begin
          state_d = PRESSED;
          cnt_d   = '0;
          level_d = 1'b1;
          press_d = 1'b1;
        end else begin
          // Only reached below DEBOUNCE_CYCLES, so the count never wraps.
          cnt_d = cnt_q + CW'(1);
        end
      end
      PRESSED: begin
        if (!pressed_s) begin
          state_d = RELEASE_WAIT;
          cnt_d   = CW'(1);
        end
      end
      RELEASE_WAIT: begin
        if (pressed_s) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CW'(DEBOUNCE_CYCLES)) begin
          state_d   = IDLE;
          cnt_d     = '0;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM, counter and registered outputs.
  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;

`ifdef BTN_LONG_PRESS_EN
  localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);

  logic [HW-1:0] hold_q, hold_d;
  logic          long_q, long_d;

  // Hold timer: restarts on a fresh press, survives a release bounce,
  // saturates so the strobe fires once per press.
  always_comb begin
    hold_d = hold_q;
    long_d = 1'b0;
    if (state_d == IDLE || (state_q == PRESS_WAIT && state_d == PRESSED)) begin
      hold_d = '0;
    end else if ((state_q == PRESSED || state_q == RELEASE_WAIT) &&
                 hold_q != HW'(LONG_PRESS_CYCLES)) begin
      hold_d = hold_q + HW'(1);
      long_d = (hold_q + HW'(1)) == HW'(LONG_PRESS_CYCLES);
    end
  end

  // Hold timer and long-press strobe registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
      long_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      long_q <= long_d;
    end
  end

  assign btn_long = long_q;
`else
  assign btn_long = 1'b0;
`endif

endmodule

// File: rtl/button_conditioner.sv
// Push-button conditioner: NUM_BTN independent synchronise/debounce channels
// producing a clean level and press/release (and optional long-press) strobes.
// Long-press strobe is enabled with `define BTN_LONG_PRESS_EN.
module button_conditioner
  import btn_pkg::*;
#(
  parameter int NUM_BTN           = 2,
  parameter bit ACTIVE_LOW        = 1'b1,
  parameter int DEBOUNCE_CYCLES   = BOARD_DEBOUNCE_CYCLES,
  parameter int LONG_PRESS_CYCLES = BOARD_LONG_PRESS_CYCLES
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [NUM_BTN-1:0] btn_long
);

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    btn_debounce_ch #(
      .ACTIVE_LOW        (ACTIVE_LOW),
      .DEBOUNCE_CYCLES   (DEBOUNCE_CYCLES),
      .LONG_PRESS_CYCLES (LONG_PRESS_CYCLES)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .btn_raw     (btn_raw[i]),
      .btn_level   (btn_level[i]),
      .btn_press   (btn_press[i]),
      .btn_release (btn_release[i]),
      .btn_long    (btn_long[i])
    );
  end

endmodule
